ram_bus_bridge: RTL

- Bus-slave front end that sits directly upstream of the single-port data RAM (14-bit word address, 32-bit data, 4 byte enables, unregistered output by default).
- Accepts byte/half/word load and store requests from the core bus through a valid/ready handshake.
- Performs address decode, alignment checks, byte-lane steering and load sign/zero extension.
- Returns one registered response per request, with one transaction outstanding at most.

---
 rtl/ram_bus_bridge.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/ram_bus_bridge.sv
// Core-bus to single-port data RAM bridge: decode, alignment checks, lane steering and load extension.
// Define RAM_BUS_BRIDGE_OREG_EN when the RAM is built with a registered output (adds RD_WAIT2).
module ram_bus_bridge #(
    parameter int          ADDR_WIDTH = 14,
    parameter int          DATA_WIDTH = 32,
    parameter int          BE_WIDTH   = DATA_WIDTH / 8,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [31:0]           req_addr_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_wr_data_o,
    output logic                  ram_wr_en_o,
    output logic [BE_WIDTH-1:0]   ram_wr_byte_en_o,
    input  logic [DATA_WIDTH-1:0] ram_rd_data_i
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
`ifdef RAM_BUS_BRIDGE_OREG_EN
        RD_WAIT2 = 2'd3,
`endif
        RSP      = 2'd2
    } state_e;

    state_e                  r_state;
    state_e                  w_state_nxt;

    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [1:0]              r_off;
    logic [1:0]              r_size;
    logic                    r_unsigned;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_err;

    logic                    w_hit;
    logic                    w_misaligned;
    logic                    w_size_err;
    logic                    w_err;
    logic                    w_accept;
    logic                    w_capture;
    logic [BE_WIDTH-1:0]     w_be;
    logic [DATA_WIDTH-1:0]   w_wr_data;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [DATA_WIDTH-1:0]   w_ext;

    // Request decode, evaluated combinationally in the accept cycle.
    assign w_hit        = (req_addr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign w_misaligned = ((req_size_i == 2'd1) && req_addr_i[0]) ||
                          ((req_size_i == 2'd2) && (req_addr_i[1:0] != 2'b00));
    assign w_size_err   = (req_size_i == 2'd3);
    assign w_err        = !w_hit || w_misaligned || w_size_err;
    assign w_accept     = req_valid_i && req_ready_o;

`ifdef RAM_BUS_BRIDGE_OREG_EN
    assign w_capture = (r_state == RD_WAIT2);
`else
    assign w_capture = (r_state == RD_WAIT);
`endif

    // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_be      = '0;
        w_wr_data = req_wdata_i;
        case (req_size_i)
            2'd0: begin
                w_be      = 4'b0001 << req_addr_i[1:0];
                w_wr_data = {4{req_wdata_i[7:0]}};
            end
            2'd1: begin
                w_be      = req_addr_i[1] ? 4'b1100 : 4'b0011;
                w_wr_data = {2{req_wdata_i[15:0]}};
            end
            2'd2: w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    assign ram_wr_data_o = w_wr_data;
    assign ram_addr_o    = (r_state == IDLE) ? req_addr_i[ADDR_WIDTH+1:2] : r_addr;

    always_comb begin
        w_byte = ram_rd_data_i[7:0];
        case (r_off)
            2'd0: w_byte = ram_rd_data_i[7:0];
            2'd1: w_byte = ram_rd_data_i[15:8];
            2'd2: w_byte = ram_rd_data_i[23:16];
            default: w_byte = ram_rd_data_i[31:24];
        endcase
        w_half = r_off[1] ? ram_rd_data_i[31:16] : ram_rd_data_i[15:0];
        case (r_size)
            2'd0:    w_ext = {{24{~r_unsigned & w_byte[7]}}, w_byte};
            2'd1:    w_ext = {{16{~r_unsigned & w_half[15]}}, w_half};
            default: w_ext = ram_rd_data_i;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        req_ready_o      = 1'b0;
        rsp_valid_o      = 1'b0;
        ram_wr_en_o      = 1'b0;
        ram_wr_byte_en_o = '0;
        case (r_state)
            IDLE: begin
                // Ready is qualified by rst so nothing is accepted or written while reset is held.
                req_ready_o = rst;
                if (req_valid_i && rst) begin
                    if (w_err) begin
                        w_state_nxt = RSP;
                    end else if (req_we_i) begin
                        ram_wr_en_o      = 1'b1;
                        ram_wr_byte_en_o = w_be;
                        w_state_nxt      = RSP;
                    end else begin
                        w_state_nxt = RD_WAIT;
                    end
                end
            end
`ifdef RAM_BUS_BRIDGE_OREG_EN
            RD_WAIT:  w_state_nxt = RD_WAIT2;
            RD_WAIT2: w_state_nxt = RSP;
`else
            RD_WAIT:  w_state_nxt = RSP;
`endif
            RSP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Response registers: cleared on every accept, loaded with extended data when the read lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr     <= '0;
            r_off      <= 2'd0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else if (w_accept) begin
            r_addr     <= req_addr_i[ADDR_WIDTH+1:2];
            r_off      <= req_addr_i[1:0];
            r_size     <= req_size_i;
            r_unsigned <= req_unsigned_i;
            r_rdata    <= '0;
            r_err      <= w_err;
        end else if (w_capture) begin
            r_rdata <= w_ext;
            r_err   <= 1'b0;
        end
    end

    assign rsp_rdata_o = r_rdata;
    assign rsp_err_o   = r_err;

endmodule
